// File: rtl/fr_pipe_stage.sv
// Flow-controlled pipeline stage register carrying an instruction word and its next PC.
// Define FR_PIPE_SKID_EN to add a skid entry so that InReady comes straight from a flop.
module fr_pipe_stage #(
   parameter int unsigned       DATA_W = 32,
   parameter int unsigned       PC_W   = 32,
   parameter int unsigned       PC_INC = 4,
   parameter logic [DATA_W-1:0] BUBBLE = '0
) (
   input  logic              Clk,
   input  logic              ResetN,
   input  logic              Flush,
   input  logic              InValid,
   output logic              InReady,
   input  logic [DATA_W-1:0] InData,
   input  logic [PC_W-1:0]   InPC,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] OutData,
   output logic [PC_W-1:0]   OutPCNext
);

   logic              r_m_valid;
   logic [DATA_W-1:0] r_m_data;
   logic [PC_W-1:0]   r_m_pc;

   logic              w_kill;
   logic              w_accept;
   logic              w_emit;
   logic              w_m_free;
   logic [PC_W-1:0]   w_in_pc_next;

   assign w_kill       = !ResetN || Flush;
   assign w_accept     = InValid && InReady;
   assign w_emit       = r_m_valid && OutReady;
   assign w_m_free     = !r_m_valid || w_emit;
   // Carry out of the PC adder is dropped: the PC wraps modulo 2^PC_W.
   assign w_in_pc_next = InPC + PC_W'(PC_INC);

`ifdef FR_PIPE_SKID_EN
   logic              r_s_valid;
   logic [DATA_W-1:0] r_s_data;
   logic [PC_W-1:0]   r_s_pc;
   logic              r_in_ready;
   logic              w_s_load;
   logic              w_s_valid_nxt;

   // S takes the incoming word whenever M is busy or is being refilled from S.
   assign w_s_load      = w_accept && (r_s_valid || !w_m_free);
   assign w_s_valid_nxt = !w_kill && (w_s_load || (r_s_valid && !w_m_free));
   assign InReady       = r_in_ready;

   always_ff @(posedge Clk) begin
      if (w_kill) begin
         r_s_valid  <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         r_s_valid  <= w_s_valid_nxt;
         r_in_ready <= !w_s_valid_nxt;
      end
   end

   // NOTE: payload flops carry no reset; r_s_valid alone decides whether they mean anything.
   always_ff @(posedge Clk) begin
      if (w_s_load) begin
         r_s_data <= InData;
         r_s_pc   <= w_in_pc_next;
      end
   end
`else
   assign InReady = !r_m_valid || OutReady;
`endif

   // NOTE: non-blocking assignments only, so every branch sees pre-edge values of the stage.
   always_ff @(posedge Clk) begin
      if (w_kill) begin
         r_m_valid <= 1'b0;
         r_m_data  <= BUBBLE;
         r_m_pc    <= '0;
      end else if (w_m_free) begin
`ifdef FR_PIPE_SKID_EN
         if (r_s_valid) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_s_data;
            r_m_pc    <= r_s_pc;
         end else
`endif
         if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= InData;
            r_m_pc    <= w_in_pc_next;
         end else begin
            r_m_valid <= 1'b0;
            r_m_data  <= BUBBLE;
            r_m_pc    <= '0;
         end
      end
   end

   assign OutValid  = r_m_valid;
   assign OutData   = r_m_data;
   assign OutPCNext = r_m_pc;

endmodule

// File: doc/fr_pipe_stage.md
# fr_pipe_stage

Parametrised, flow-controlled pipeline stage register that supersedes the fixed IF/ID latch in the five-stage pipeline. It carries one instruction word plus its PC between two adjacent stages. It provides a valid/ready handshake, stall by back-pressure, and a flush that inserts a bubble. The stage computes the sequential next PC (`PC + PC_INC`) on capture and, optionally, holds a second entry in a skid buffer so that `InReady` is a registered signal.

## Interface
- `DATA_W`, default 32: instruction/payload width.
- `PC_W`, default 32: PC width.
- `PC_INC`, default 4: increment added to the captured PC.
- `BUBBLE`, default 0: payload value presented while the stage is empty (nop).

Ports:
- `Clk`, input, 1: clock; all state updates on the rising edge.
- `ResetN`, input, 1: synchronous, active-low reset.
- `Flush`, input, 1: discard all held entries, synchronous.
- `InValid`, input, 1: upstream has a word.
- `InReady`, output, 1: stage can accept a word.
- `InData`, input, `DATA_W`: instruction in.
- `InPC`, input, `PC_W`: PC of `InData`.
- `OutValid`, output, 1: the head entry is valid.
- `OutReady`, input, 1: downstream consumes the head entry.
- `OutData`, output, `DATA_W`: head instruction, or `BUBBLE` when empty.
- `OutPCNext`, output, `PC_W`: head PC + `PC_INC`, or 0 when empty.

## Operation
- Accept occurs when `InValid && InReady`; emit occurs when `OutValid && OutReady`.
- Storage consists of a main entry M, which drives the outputs, and a skid entry S. S exists only with `FR_PIPE_SKID_EN`.
- On capture, the stage stores `InData` unchanged and stores `InPC + PC_INC` truncated to `PC_W` bits (modulo 2^PC_W; carry dropped).
- Per-cycle update, in priority order:
  - `ResetN==0` or `Flush==1`:
    - M and S become empty.
    - M data becomes `BUBBLE`; M PC becomes 0.
    - `InReady` becomes 1.
    - A concurrent accept is dropped.
  - M empty, or emit this cycle:
    - If S is full, move S to M. Any accept this cycle goes to S.
    - Otherwise the accepted word goes to M.
    - If no word is available, M becomes empty and loads `BUBBLE`/0.
  - M full and no emit: an accept goes to S.
- `InReady` (skid build) is the registered value of "S will be empty next cycle".
- Ordering is strictly FIFO. No word is ever duplicated or lost, except on flush or reset.
- States (skid build): EMPTY (M–,S–), ONE (M+,S–), FULL (M+,S+).
  - EMPTY → ONE on accept.
  - ONE → FULL on accept without emit.
  - ONE → EMPTY on emit without accept.
  - FULL → ONE on emit. No accept is possible in FULL.
  - Any state → EMPTY on flush or reset.

## Timing
- Reset values:
  - `OutValid`=0
  - `OutData`=`BUBBLE`
  - `OutPCNext`=0
  - `InReady`=1
  - Inputs sampled while `ResetN` is low are ignored.
- Latency is 1 cycle: a word accepted at edge *n* is visible on `OutData`/`OutPCNext` after edge *n*.
- Throughput is 1 word/cycle while `OutReady` is held high.
- Back-pressure:
  - When `OutReady` is low with M full, one more word is absorbed into S.
  - `InReady` falls after the edge that fills S.
  - `InReady` returns high after the edge on which S drains into M.
- A word held at the output stays stable (data and PC) until emitted or flushed.
- `Flush` and `OutReady` in the same cycle: flush wins. The head word counts as consumed by downstream; the stage clears regardless.
- Flush has an effect one edge later: a bubble is output in the next cycle.

## Configuration
- `FR_PIPE_SKID_EN` defined:
  - Two entries (M + S).
  - `InReady` is a flop output, with no combinational path from `OutReady` to `InReady`.
- `FR_PIPE_SKID_EN` undefined:
  - M only.
  - `InReady = !OutValid || OutReady` (combinational).
  - Flush/reset behaviour is unchanged.
  - The FULL state does not exist.

## Test plan
- Reset: hold `ResetN`=0 for 2 cycles with `InValid`=1 and `InData`=0x12345678 → `OutValid`=0, `OutData`=0, `OutPCNext`=0, `InReady`=1. Nothing is captured.
- Single transfer: `InData`=0x8C010004, `InPC`=0x00003000, `OutReady`=1 → next cycle `OutValid`=1, `OutData`=0x8C010004, `OutPCNext`=0x00003004. The cycle after that `OutValid`=0 and `OutData`=`BUBBLE`.
- Stall (skid build): hold `OutReady`=0 and offer A then B on consecutive cycles → both are accepted and `InReady`=0 afterwards. Release `OutReady` → A then B are emitted in order. `InReady` returns to 1 one cycle after A is emitted.
- Flush in FULL with `InValid`=1 and `InData`=C in the same cycle → next cycle `OutValid`=0, `InReady`=1. C never appears.
- PC wrap: `InPC`=0xFFFFFFFC → `OutPCNext`=0x00000000.
- Streaming: feed 8 consecutive words with `OutReady`=1 → 8 emits on 8 consecutive cycles and `InReady` stays 1. Repeat without `FR_PIPE_SKID_EN` and with random `OutReady`; a scoreboard confirms order.
